branch_presolve_stage: RTL and testbench

Registered, parametrised pre-decode stage between instruction fetch and the decode queue. It checks each fetch pack against its branch prediction and corrects two cases one cycle after the pack is accepted. A predicted-taken slot that holds no control-flow instruction is redirected to the sequential path. An unpredicted or mispredicted direct JAL is redirected to its computed target. Younger slots on the wrong path are squashed and the pack is forwarded downstream through a one-entry valid/ready buffer.

---
 rtl/frontend_pkg.sv | 20 ++
 rtl/branch_presolve_stage_slot_decode.sv | 29 ++
 rtl/branch_presolve_stage.sv | 152 +++++++++++++++
 tb/tb_branch_presolve_stage.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frontend_pkg.sv
// Shared frontend definitions: RISC-V control-flow opcodes and pack helpers.
package frontend_pkg;

  typedef enum logic [6:0] {
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  // J-type immediate, sign-extended to 64 bits; callers truncate to XLEN.
  function automatic logic [63:0] jal_imm(input logic [31:0] inst);
    return {{44{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // Aligns a PC down to the start of its fetch pack (fetchWidth slots of 4 bytes).
  function automatic logic [63:0] pack_base(input logic [63:0] pc, input int unsigned fetchWidth);
    return pc & ~((64'(fetchWidth) << 2) - 64'd1);
  endfunction

endpackage

// File: rtl/branch_presolve_stage_slot_decode.sv
// Per-slot pre-decode: control-flow / JAL classification and JAL target.
module presolve_slot_decode
  import frontend_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     inst,
  input  logic            valid,
  input  logic [XLEN-1:0] pc,
  output logic            cfi,
  output logic            jal,
  output logic [XLEN-1:0] target
);

  logic [63:0] immFull;
  logic        unusedRd;

  assign unusedRd = ^inst[11:7];

  // Classify the slot opcode and compute the JAL target from the slot PC.
  always_comb begin
    immFull = jal_imm(inst);
    cfi     = valid && ((inst[6:0] == OPC_BRANCH) || (inst[6:0] == OPC_JAL) ||
                        (inst[6:0] == OPC_JALR));
    jal     = valid && (inst[6:0] == OPC_JAL);
    target  = pc + immFull[XLEN-1:0];
  end

endmodule

// File: rtl/branch_presolve_stage.sv
// Fetch-pack pre-decode stage: corrects false-taken predictions and presolves
// direct JALs, squashes wrong-path slots and buffers the pack for decode.
module branch_presolve_stage
  import frontend_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH  = 2,
  parameter int unsigned XLEN         = 64,
  parameter int unsigned PRESOLVE_JAL = 1,
  localparam int unsigned SW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_i_valid,
  output logic                     io_o_ready,
  input  logic [FETCH_WIDTH-1:0]   io_i_fetch_pack_valids,
  input  logic [XLEN-1:0]          io_i_fetch_pack_pc,
  input  logic [32*FETCH_WIDTH-1:0] io_i_fetch_pack_insts,
  input  logic                     io_i_fetch_pack_branch_predict_pack_valid,
  input  logic                     io_i_fetch_pack_branch_predict_pack_taken,
  input  logic [SW-1:0]            io_i_fetch_pack_branch_predict_pack_select,
  input  logic [XLEN-1:0]          io_i_fetch_pack_branch_predict_pack_target,
  input  logic [3:0]               io_i_fetch_pack_branch_predict_pack_branch_type,
  input  logic                     io_i_flush,
  output logic                     io_o_valid,
  input  logic                     io_i_ready,
  output logic [FETCH_WIDTH-1:0]   io_o_fetch_pack_valids,
  output logic [XLEN-1:0]          io_o_fetch_pack_pc,
  output logic [32*FETCH_WIDTH-1:0] io_o_fetch_pack_insts,
  output logic                     io_o_fetch_pack_branch_predict_pack_valid,
  output logic                     io_o_fetch_pack_branch_predict_pack_taken,
  output logic [SW-1:0]            io_o_fetch_pack_branch_predict_pack_select,
  output logic [XLEN-1:0]          io_o_fetch_pack_branch_predict_pack_target,
  output logic [3:0]               io_o_fetch_pack_branch_predict_pack_branch_type,
  output logic                     io_o_branch_presolve_pack_valid,
  output logic                     io_o_branch_presolve_pack_taken,
  output logic [XLEN-1:0]          io_o_branch_presolve_pack_pc
);

  logic [63:0]            baseFull;
  logic [XLEN-1:0]        base;
  logic [FETCH_WIDTH-1:0] slotCfi;
  logic [FETCH_WIDTH-1:0] slotJal;
  logic [XLEN-1:0]        slotPc     [FETCH_WIDTH];
  logic [XLEN-1:0]        slotTarget [FETCH_WIDTH];

  logic                   predValid;
  logic                   predSlotCfi;
  logic                   jalFound;
  logic [SW-1:0]          jalIdx;
  logic [XLEN-1:0]        jalTarget;
  logic                   jalFire;
  logic                   ftFire;
  logic                   fire;
  logic [XLEN-1:0]        firePc;
  logic [SW-1:0]          keepIdx;
  logic [FETCH_WIDTH-1:0] maskedValids;
  logic                   accept;

  assign baseFull = pack_base(64'(io_i_fetch_pack_pc), FETCH_WIDTH);
  assign base     = baseFull[XLEN-1:0];

  for (genvar s = 0; s < FETCH_WIDTH; s++) begin : gSlot
    assign slotPc[s] = base + XLEN'(4 * s);
    presolve_slot_decode #(.XLEN(XLEN)) uDecode (
      .inst   (io_i_fetch_pack_insts[32*s +: 32]),
      .valid  (io_i_fetch_pack_valids[s]),
      .pc     (slotPc[s]),
      .cfi    (slotCfi[s]),
      .jal    (slotJal[s]),
      .target (slotTarget[s])
    );
  end

  // Lowest-JAL search, rule arbitration (JAL presolve beats false-taken) and squash mask.
  always_comb begin
    predValid   = io_i_fetch_pack_branch_predict_pack_valid &&
                  io_i_fetch_pack_branch_predict_pack_taken;
    jalFound    = 1'b0;
    jalIdx      = '0;
    jalTarget   = '0;
    predSlotCfi = 1'b0;
    // Descending scan so the lowest matching slot is the one left standing.
    for (int unsigned s = FETCH_WIDTH; s > 0; s--) begin
      if (slotJal[s-1]) begin
        jalFound  = 1'b1;
        jalIdx    = SW'(s - 1);
        jalTarget = slotTarget[s-1];
      end
    end
    for (int unsigned s = 0; s < FETCH_WIDTH; s++) begin
      if (SW'(s) == io_i_fetch_pack_branch_predict_pack_select) begin
        predSlotCfi = slotCfi[s];
      end
    end
    jalFire = (PRESOLVE_JAL != 0) && jalFound &&
              (!predValid || (jalIdx < io_i_fetch_pack_branch_predict_pack_select) ||
               ((jalIdx == io_i_fetch_pack_branch_predict_pack_select) &&
                (io_i_fetch_pack_branch_predict_pack_target != jalTarget)));
    ftFire  = predValid && !predSlotCfi;
    fire    = jalFire || ftFire;
    firePc  = jalFire ? jalTarget
                      : base + ((XLEN'(io_i_fetch_pack_branch_predict_pack_select) + XLEN'(1)) << 2);
    keepIdx = jalFire ? jalIdx : io_i_fetch_pack_branch_predict_pack_select;
    for (int unsigned s = 0; s < FETCH_WIDTH; s++) begin
      maskedValids[s] = io_i_fetch_pack_valids[s] && (!fire || (SW'(s) <= keepIdx));
    end
  end

  assign io_o_ready = (!io_o_valid || io_i_ready) && !io_o_branch_presolve_pack_valid && !io_i_flush;
  assign accept     = io_i_valid && io_o_ready;

  // One-entry output buffer plus single-cycle redirect pulse; flush drops both.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_o_valid                                      <= 1'b0;
      io_o_fetch_pack_valids                          <= '0;
      io_o_fetch_pack_pc                              <= '0;
      io_o_fetch_pack_insts                           <= '0;
      io_o_fetch_pack_branch_predict_pack_valid       <= 1'b0;
      io_o_fetch_pack_branch_predict_pack_taken       <= 1'b0;
      io_o_fetch_pack_branch_predict_pack_select      <= '0;
      io_o_fetch_pack_branch_predict_pack_target      <= '0;
      io_o_fetch_pack_branch_predict_pack_branch_type <= '0;
      io_o_branch_presolve_pack_valid                 <= 1'b0;
      io_o_branch_presolve_pack_taken                 <= 1'b0;
      io_o_branch_presolve_pack_pc                    <= '0;
    end else if (io_i_flush) begin
      io_o_valid                      <= 1'b0;
      io_o_branch_presolve_pack_valid <= 1'b0;
    end else begin
      io_o_branch_presolve_pack_valid <= accept && fire;
      if (accept) begin
        io_o_valid                                      <= 1'b1;
        io_o_fetch_pack_valids                          <= maskedValids;
        io_o_fetch_pack_pc                              <= io_i_fetch_pack_pc;
        io_o_fetch_pack_insts                           <= io_i_fetch_pack_insts;
        io_o_fetch_pack_branch_predict_pack_valid       <= io_i_fetch_pack_branch_predict_pack_valid;
        io_o_fetch_pack_branch_predict_pack_taken       <= io_i_fetch_pack_branch_predict_pack_taken;
        io_o_fetch_pack_branch_predict_pack_select      <= io_i_fetch_pack_branch_predict_pack_select;
        io_o_fetch_pack_branch_predict_pack_target      <= io_i_fetch_pack_branch_predict_pack_target;
        io_o_fetch_pack_branch_predict_pack_branch_type <= io_i_fetch_pack_branch_predict_pack_branch_type;
        if (fire) begin
          io_o_branch_presolve_pack_taken <= jalFire;
          io_o_branch_presolve_pack_pc    <= firePc;
        end
      end else if (io_i_ready) begin
        io_o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_branch_presolve_stage.sv
module tb_branch_presolve_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus (FETCH_WIDTH=2 instances take the low slices).
  logic         rst, sValid, sPv, sPt, sFlush, sReady;
  logic [3:0]   sV, sBt;
  logic [63:0]  sPc, sTgt;
  logic [127:0] sIns;
  logic [1:0]   sSel;

  // Per-instance outputs: 0 = FW2/JAL on, 1 = FW4/JAL on, 2 = FW2/JAL off.
  logic         xReady [3], xValid [3], xPv [3], xPt [3], xRv [3], xRt [3];
  logic [63:0]  xPc [3], xTgt [3], xRpc [3];
  logic [3:0]   xBt [3];
  logic [1:0]   aValids, cValids;
  logic [3:0]   bValids;
  logic [63:0]  aIns, cIns;
  logic [127:0] bIns;
  logic         aSel, cSel;
  logic [1:0]   bSel;

  branch_presolve_stage #(.FETCH_WIDTH(2), .XLEN(64), .PRESOLVE_JAL(1)) dutA (
    .clock(clk), .reset(rst), .io_i_valid(sValid), .io_o_ready(xReady[0]),
    .io_i_fetch_pack_valids(sV[1:0]), .io_i_fetch_pack_pc(sPc), .io_i_fetch_pack_insts(sIns[63:0]),
    .io_i_fetch_pack_branch_predict_pack_valid(sPv), .io_i_fetch_pack_branch_predict_pack_taken(sPt),
    .io_i_fetch_pack_branch_predict_pack_select(sSel[0:0]), .io_i_fetch_pack_branch_predict_pack_target(sTgt),
    .io_i_fetch_pack_branch_predict_pack_branch_type(sBt), .io_i_flush(sFlush),
    .io_o_valid(xValid[0]), .io_i_ready(sReady),
    .io_o_fetch_pack_valids(aValids), .io_o_fetch_pack_pc(xPc[0]), .io_o_fetch_pack_insts(aIns),
    .io_o_fetch_pack_branch_predict_pack_valid(xPv[0]), .io_o_fetch_pack_branch_predict_pack_taken(xPt[0]),
    .io_o_fetch_pack_branch_predict_pack_select(aSel), .io_o_fetch_pack_branch_predict_pack_target(xTgt[0]),
    .io_o_fetch_pack_branch_predict_pack_branch_type(xBt[0]),
    .io_o_branch_presolve_pack_valid(xRv[0]), .io_o_branch_presolve_pack_taken(xRt[0]),
    .io_o_branch_presolve_pack_pc(xRpc[0])
  );

  branch_presolve_stage #(.FETCH_WIDTH(4), .XLEN(64), .PRESOLVE_JAL(1)) dutB (
    .clock(clk), .reset(rst), .io_i_valid(sValid), .io_o_ready(xReady[1]),
    .io_i_fetch_pack_valids(sV), .io_i_fetch_pack_pc(sPc), .io_i_fetch_pack_insts(sIns),
    .io_i_fetch_pack_branch_predict_pack_valid(sPv), .io_i_fetch_pack_branch_predict_pack_taken(sPt),
    .io_i_fetch_pack_branch_predict_pack_select(sSel), .io_i_fetch_pack_branch_predict_pack_target(sTgt),
    .io_i_fetch_pack_branch_predict_pack_branch_type(sBt), .io_i_flush(sFlush),
    .io_o_valid(xValid[1]), .io_i_ready(sReady),
    .io_o_fetch_pack_valids(bValids), .io_o_fetch_pack_pc(xPc[1]), .io_o_fetch_pack_insts(bIns),
    .io_o_fetch_pack_branch_predict_pack_valid(xPv[1]), .io_o_fetch_pack_branch_predict_pack_taken(xPt[1]),
    .io_o_fetch_pack_branch_predict_pack_select(bSel), .io_o_fetch_pack_branch_predict_pack_target(xTgt[1]),
    .io_o_fetch_pack_branch_predict_pack_branch_type(xBt[1]),
    .io_o_branch_presolve_pack_valid(xRv[1]), .io_o_branch_presolve_pack_taken(xRt[1]),
    .io_o_branch_presolve_pack_pc(xRpc[1])
  );

  branch_presolve_stage #(.FETCH_WIDTH(2), .XLEN(64), .PRESOLVE_JAL(0)) dutC (
    .clock(clk), .reset(rst), .io_i_valid(sValid), .io_o_ready(xReady[2]),
    .io_i_fetch_pack_valids(sV[1:0]), .io_i_fetch_pack_pc(sPc), .io_i_fetch_pack_insts(sIns[63:0]),
    .io_i_fetch_pack_branch_predict_pack_valid(sPv), .io_i_fetch_pack_branch_predict_pack_taken(sPt),
    .io_i_fetch_pack_branch_predict_pack_select(sSel[0:0]), .io_i_fetch_pack_branch_predict_pack_target(sTgt),
    .io_i_fetch_pack_branch_predict_pack_branch_type(sBt), .io_i_flush(sFlush),
    .io_o_valid(xValid[2]), .io_i_ready(sReady),
    .io_o_fetch_pack_valids(cValids), .io_o_fetch_pack_pc(xPc[2]), .io_o_fetch_pack_insts(cIns),
    .io_o_fetch_pack_branch_predict_pack_valid(xPv[2]), .io_o_fetch_pack_branch_predict_pack_taken(xPt[2]),
    .io_o_fetch_pack_branch_predict_pack_select(cSel), .io_o_fetch_pack_branch_predict_pack_target(xTgt[2]),
    .io_o_fetch_pack_branch_predict_pack_branch_type(xBt[2]),
    .io_o_branch_presolve_pack_valid(xRv[2]), .io_o_branch_presolve_pack_taken(xRt[2]),
    .io_o_branch_presolve_pack_pc(xRpc[2])
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: apply the presolve rules slot by slot on plain integers.
  function automatic void presolve(input int fw, input int pj, input logic [3:0] v, input logic [63:0] pc,
                                   input logic [127:0] ins, input logic pv, input logic pt, input int sel,
                                   input logic [63:0] tgt, output logic fire, output logic taken,
                                   output logic [63:0] rpc, output logic [3:0] ov);
    logic [63:0] base, tj;
    logic [31:0] w;
    logic [20:0] raw;
    int j, cut;
    base = pc - (pc % 64'(fw * 4));
    j = -1;
    tj = '0;
    for (int s = 0; s < fw; s++) begin
      w = ins[32*s +: 32];
      if (j < 0 && v[s] && w[6:0] == 7'h6F) begin
        j = s;
        raw = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        tj = base + 64'(4 * s) + {{43{raw[20]}}, raw};
      end
    end
    fire = 1'b0; taken = 1'b0; rpc = '0; cut = fw - 1;
    if (pj != 0 && j >= 0 && (!(pv && pt) || j < sel || (j == sel && tgt != tj))) begin
      fire = 1'b1; taken = 1'b1; rpc = tj; cut = j;
    end else if (pv && pt) begin
      w = ins[32*sel +: 32];
      if (!v[sel] || !(w[6:0] inside {7'h63, 7'h6F, 7'h67})) begin
        fire = 1'b1; rpc = base + 64'(4 * (sel + 1)); cut = sel;
      end
    end
    ov = '0;
    for (int s = 0; s < fw; s++) ov[s] = v[s] && (s <= cut);
  endfunction

  // Expected state of the FETCH_WIDTH=4 instance.
  logic         mValid = 0, mRv = 0, mRt = 0, mPv = 0, mPt = 0;
  logic [63:0]  mRpc = 0, mPc = 0, mTgt = 0;
  logic [3:0]   mV = 0, mBt = 0;
  logic [1:0]   mSel = 0;
  logic [127:0] mIns = 0;

  task automatic cycle();
    logic eReady, fire, taken;
    logic [63:0] rpc;
    logic [3:0] ov;
    #1;
    eReady = (!mValid || sReady) && !mRv && !sFlush;
    if (!rst) chk("ready", 128'(xReady[1]), 128'(eReady));
    @(posedge clk);
    presolve(4, 1, sV, sPc, sIns, sPv, sPt, int'(sSel), sTgt, fire, taken, rpc, ov);
    if (rst) begin
      mValid = 0; mRv = 0; mRt = 0; mRpc = 0; mPc = 0; mIns = 0; mV = 0;
      mPv = 0; mPt = 0; mSel = 0; mTgt = 0; mBt = 0;
    end else if (sFlush) begin
      mValid = 0; mRv = 0;
    end else begin
      mRv = sValid && eReady && fire;
      if (sValid && eReady) begin
        mValid = 1; mV = ov; mPc = sPc; mIns = sIns; mPv = sPv; mPt = sPt;
        mSel = sSel; mTgt = sTgt; mBt = sBt; mRt = taken; mRpc = rpc;
      end else if (sReady) begin
        mValid = 0;
      end
    end
    #1;
    if (!rst) begin
      chk("o_valid", 128'(xValid[1]), 128'(mValid));
      chk("redirect_valid", 128'(xRv[1]), 128'(mRv));
      if (mRv) begin
        chk("redirect_taken", 128'(xRt[1]), 128'(mRt));
        chk("redirect_pc", 128'(xRpc[1]), 128'(mRpc));
      end
      if (mValid) begin
        chk("pack_valids", 128'(bValids), 128'(mV));
        chk("pack_pc", 128'(xPc[1]), 128'(mPc));
        chk("pack_insts", bIns, mIns);
        chk("pack_pred", 128'({xPv[1], xPt[1], bSel, xTgt[1], xBt[1]}), 128'({mPv, mPt, mSel, mTgt, mBt}));
      end
    end
  endtask

  function automatic logic [31:0] rndInst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: return {r[31:7], 7'h6F};
      1: return {r[31:7], 7'h63};
      2: return {r[31:7], 7'h67};
      3: return 32'h00000013;
      default: return r;
    endcase
  endfunction

  typedef struct {
    int           inst;
    logic [3:0]   v;
    logic [63:0]  pc;
    logic [127:0] ins;
    logic         pv, pt;
    logic [1:0]   sel;
    logic [63:0]  tgt;
    logic         eFire, eTaken;
    logic [63:0]  ePc;
    logic [3:0]   eV;
  } vec_t;

  vec_t tbl[9];

  task automatic applyVec(input vec_t e);
    sValid = 1; sReady = 1; sFlush = 0; sV = e.v; sPc = e.pc; sIns = e.ins;
    sPv = e.pv; sPt = e.pt; sSel = e.sel; sTgt = e.tgt; sBt = 4'h5;
  endtask

  initial begin
    logic [3:0] selV;
    logic [63:0] tmp, base;
    logic [31:0] w;
    tbl[0] = '{0, 4'b0011, 64'h8000_0004, {64'h0, 32'h00000033, 32'h00000013}, 1, 1, 2'd0, 64'h0,
               1, 0, 64'h8000_0004, 4'b0001};
    tbl[1] = '{1, 4'b1111, 64'h1000, {32'h13, 32'h1000006F, 32'h13, 32'h13}, 0, 0, 2'd0, 64'h0,
               1, 1, 64'h1108, 4'b0111};
    tbl[2] = '{0, 4'b0011, 64'h0, {64'h0, 32'hFF9FF06F, 32'h13}, 1, 1, 2'd1, 64'hFFFF_FFFF_FFFF_FFFC,
               0, 0, 64'h0, 4'b0011};
    tbl[3] = '{0, 4'b0011, 64'h0, {64'h0, 32'hFF9FF06F, 32'h13}, 1, 1, 2'd1, 64'h0,
               1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 4'b0011};
    tbl[4] = '{2, 4'b0011, 64'h0, {64'h0, 32'h13, 32'h1000006F}, 0, 0, 2'd0, 64'h0,
               0, 0, 64'h0, 4'b0011};
    tbl[5] = '{1, 4'b1111, 64'h2008, {32'h13, 32'h63, 32'h13, 32'h13}, 1, 1, 2'd2, 64'h1234,
               0, 0, 64'h0, 4'b1111};
    tbl[6] = '{1, 4'b0111, 64'h200C, {32'h13, 32'h13, 32'h13, 32'h13}, 1, 1, 2'd3, 64'h1234,
               1, 0, 64'h2010, 4'b0111};
    tbl[7] = '{1, 4'b1111, 64'h3000, {32'h00008067, 32'h13, 32'h1000006F, 32'h13}, 1, 1, 2'd3, 64'h4000,
               1, 1, 64'h3104, 4'b0011};
    tbl[8] = '{0, 4'b0011, 64'h40, {64'h0, 32'h13, 32'h13}, 1, 0, 2'd1, 64'h0,
               0, 0, 64'h0, 4'b0011};

    rst = 1; sValid = 0; sV = 0; sPc = 0; sIns = 0; sPv = 0; sPt = 0; sSel = 0;
    sTgt = 0; sBt = 0; sFlush = 0; sReady = 1;
    cycle(); cycle();
    rst = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_o_valid", 128'(xValid[i]), 128'(0));
      chk("reset_redirect", 128'({xRv[i], xRt[i], xRpc[i]}), 128'(0));
      chk("reset_pack", 128'({xPc[i], xTgt[i], xPv[i], xPt[i], xBt[i]}), 128'(0));
    end
    chk("reset_insts_valids", bIns | 128'({aValids, bValids, cValids}), 128'(0));

    // Table vectors: one accepted pack, then an idle drain cycle.
    for (int i = 0; i < 9; i++) begin
      applyVec(tbl[i]);
      cycle();
      case (tbl[i].inst)
        0: selV = {2'b00, aValids};
        1: selV = bValids;
        default: selV = {2'b00, cValids};
      endcase
      chk($sformatf("tbl%0d_redirect", i), 128'(xRv[tbl[i].inst]), 128'(tbl[i].eFire));
      if (tbl[i].eFire) begin
        chk($sformatf("tbl%0d_taken", i), 128'(xRt[tbl[i].inst]), 128'(tbl[i].eTaken));
        chk($sformatf("tbl%0d_pc", i), 128'(xRpc[tbl[i].inst]), 128'(tbl[i].ePc));
      end
      chk($sformatf("tbl%0d_valids", i), 128'(selV), 128'(tbl[i].eV));
      sValid = 0;
      cycle();
    end

    // Redirect followed by a 3-cycle downstream stall.
    applyVec(tbl[1]);
    cycle();
    chk("stall_pulse", 128'(xRv[1]), 128'(1));
    sPc = 64'h5000; sIns = {4{32'h13}}; sPv = 0; sV = 4'hF; sReady = 0;
    #1 chk("stall_refuse_in_pulse", 128'(xReady[1]), 128'(0));
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall_pulse_once", 128'(xRv[1]), 128'(0));
      chk("stall_hold_pc", 128'(xPc[1]), 128'(64'h1000));
      chk("stall_hold_valids", 128'(bValids), 128'(4'b0111));
    end
    sReady = 1;
    cycle();
    chk("stall_second_pack", 128'(xPc[1]), 128'(64'h5000));
    sValid = 0;
    cycle();

    // Flush with a same-cycle request, then flush during a pending redirect.
    applyVec(tbl[1]);
    sFlush = 1;
    cycle();
    chk("flush_accept", 128'({xValid[1], xRv[1]}), 128'(0));
    sFlush = 0;
    cycle();
    chk("flush_setup_pulse", 128'(xRv[1]), 128'(1));
    sFlush = 1;
    cycle();
    chk("flush_pending", 128'({xValid[1], xRv[1]}), 128'(0));
    sFlush = 0; sValid = 0;
    cycle();

    // Full throughput with no redirects.
    for (int k = 0; k < 4; k++) begin
      sValid = 1; sReady = 1; sV = 4'hF; sPv = 0; sIns = {4{32'h13}};
      sPc = 64'h6000 + 64'(16 * k);
      #1 chk("thru_ready", 128'(xReady[1]), 128'(1));
      cycle();
      chk("thru_pc", 128'(xPc[1]), 128'(sPc));
    end

    // Reset in the middle of a redirect.
    applyVec(tbl[1]);
    cycle();
    rst = 1;
    cycle();
    chk("midreset_state", 128'({xValid[1], xRv[1], xRt[1], bValids}), 128'(0));
    chk("midreset_pcs", 128'({xPc[1], xRpc[1]}), 128'(0));
    rst = 0; sValid = 0;
    cycle();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 500; n++) begin
      sValid = ($urandom_range(0, 9) < 8);
      sReady = ($urandom_range(0, 9) < 7);
      sFlush = ($urandom_range(0, 24) == 0);
      tmp = {$urandom, $urandom};
      sPc = tmp;
      sV = 4'($urandom);
      for (int s = 0; s < 4; s++) sIns[32*s +: 32] = rndInst();
      sPv = 1'($urandom); sPt = 1'($urandom); sSel = 2'($urandom); sBt = 4'($urandom);
      sTgt = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        base = sPc - (sPc % 64'd16);
        w = sIns[32*int'(sSel) +: 32];
        sTgt = base + 64'(4 * int'(sSel)) + {{44{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
